game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SERVE_DELAY, 60: frames the ball is held at centre before a serve.
- WIN_SCORE, 7: points that end the game.
- X_MIN, 0: left goal line.
- X_MAX, 639: right goal line.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- frame_clk, in, 1: sole clock, one rising edge per video frame.
- Reset, in, 1: asynchronous, active-high reset.
- start, in, 1: key level; its rising edge requests a game start.
- BallX, in, 10: ball centre X, from the ball block.
- BallY, in, 10: ball centre Y, informational only.
- BallS, in, 10: ball radius.
- hit, in, 1: paddle/wall-bitmap collision flag (same signal as the ball's bit_on).
- ball_rst, out, 1: holds the ball block in reset (ball at centre).
- score_l, out, 4: left player score.
- score_r, out, 4: right player score.
- rally, out, 8: paddle hits in the current point.
- state, out, 3: current FSM state code.
- game_over, out, 1: high while in GAME_OVER.
- winner, out, 1: 0 = left, 1 = right; valid when game_over = 1.

Function
REQ-003 The FSM SHALL have five states with these codes: IDLE=0, SERVE=1, PLAY=2, SCORED=3, GAME_OVER=4; codes 5-7 SHALL go to IDLE on the next edge.
REQ-004 start_rise SHALL be start AND NOT start_q, where start_q is start registered on frame_clk.
REQ-005 IDLE: ball_rst=1; on start_rise, clear score_l, score_r and rally, zero the delay counter, and go to SERVE.
REQ-006 SERVE: ball_rst=1; the delay counter SHALL increment each frame and go to PLAY on the edge where it equals SERVE_DELAY-1, clearing the counter (SERVE lasts exactly SERVE_DELAY frames).
REQ-007 PLAY: ball_rst=0; rally SHALL increment on each frame with hit=1 and saturate at 255.
REQ-008 PLAY: left goal is BallX <= X_MIN + BallS, compared in 11 bits with no wrap, even when BallX < BallS.
REQ-009 PLAY: right goal is BallX + BallS >= X_MAX, compared in 11 bits.
REQ-010 On a left goal, latch scorer = right; on a right goal, latch scorer = left; then go to SCORED.
REQ-011 If both goals are true in the same frame, the left goal SHALL win (scorer = right).
REQ-012 If a goal and hit occur in the same frame, the goal SHALL take effect and rally SHALL still increment.
REQ-013 SCORED lasts one frame: ball_rst=1; increment the scorer's score; clear rally.
REQ-014 From SCORED: if the incremented score equals WIN_SCORE, set winner and go to GAME_OVER; otherwise go to SERVE with the counter at 0.
REQ-015 Scores SHALL never exceed WIN_SCORE, and WIN_SCORE SHALL be at most 15.
REQ-016 GAME_OVER: ball_rst=1; scores and winner held; on start_rise, clear scores and rally and go to SERVE.
REQ-017 start_rise in SERVE, PLAY or SCORED SHALL be ignored.
REQ-018 All outputs SHALL be registered, or decoded combinationally from state only; no input-to-output combinational path.

Reset
REQ-019 On Reset=1, asynchronously and regardless of frame_clk, the block SHALL set:
- state=IDLE, ball_rst=1
- score_l=0, score_r=0, rally=0
- delay counter=0, start_q=0
- game_over=0, winner=0
REQ-020 Reset asserted mid-PLAY or mid-SERVE SHALL abort the point with no score change; after release the block waits in IDLE for start_rise.
REQ-021 If start is held high through Reset release, no game SHALL start until start falls and rises again.

Verification
REQ-022 Reset, then start rising at frame 5 -> state=SERVE at frame 6; ball_rst=1 for 60 frames; state=PLAY and ball_rst=0 at frame 66.
REQ-023 In PLAY with BallS=4: BallX=4 -> SCORED next frame, score_r=1, then SERVE; BallX=635 -> score_l=1.
REQ-024 In PLAY, BallS=4, BallX=2 (underflow case) -> left goal detected, score_r increments and does not wrap.
REQ-025 score_l=6, right goal -> SCORED, score_l=7, GAME_OVER, game_over=1, winner=0; a further start_rise -> SERVE with scores 0.
REQ-026 hit held for 300 frames in PLAY -> rally saturates at 255; a goal in the same frame as a hit -> SCORED and rally cleared.
REQ-027 Reset pulsed mid-SERVE with start held high -> IDLE, scores 0; no SERVE until start falls and rises again.

Source files
------------

// File: rtl/game_ctrl.sv
// Game sequencer for a two-player ball game: serve delay, goal detection,
// scoring, rally counting and game-over handling. One clock edge per frame.
module game_ctrl #(
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 7,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 639
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  input  logic       hit,
  output logic       ball_rst,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [7:0] rally,
  output logic [2:0] state,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    SCORED    = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam int             DW         = $clog2(SERVE_DELAY + 1);
  localparam logic [DW-1:0]  DELAY_LAST = DW'(SERVE_DELAY - 1);
  localparam logic [3:0]     WIN        = 4'(WIN_SCORE);
  localparam logic [10:0]    XMIN11     = 11'(X_MIN);
  localparam logic [10:0]    XMAX11     = 11'(X_MAX);

  state_t        state_q, state_d;
  logic          start_q;
  logic          armed;
  logic [DW-1:0] delay_q, delay_d;
  logic [3:0]    score_l_d, score_r_d;
  logic [7:0]    rally_d;
  logic          winner_d;
  logic          scorer_q, scorer_d;   // 1 = right player scored

  logic          start_rise;
  logic          go_cmd;
  logic          goal_l, goal_r;
  logic [3:0]    inc_l, inc_r;
  logic          ball_y_unused;

  assign ball_y_unused = ^BallY;

  assign start_rise = start & ~start_q;
  // armed stays low after reset until start is seen low, so a key held
  // through reset release cannot look like a fresh press.
  assign go_cmd     = start_rise & armed;

  // Goal tests widened to 11 bits so BallX < BallS cannot wrap.
  assign goal_l = ({1'b0, BallX} <= (XMIN11 + {1'b0, BallS}));
  assign goal_r = (({1'b0, BallX} + {1'b0, BallS}) >= XMAX11);

  assign inc_l = (score_l < WIN) ? score_l + 4'd1 : score_l;
  assign inc_r = (score_r < WIN) ? score_r + 4'd1 : score_r;

  assign state     = state_q;
  assign ball_rst  = (state_q != PLAY);
  assign game_over = (state_q == GAME_OVER);

  // State register and datapath registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      armed    <= 1'b0;
      delay_q  <= '0;
      score_l  <= '0;
      score_r  <= '0;
      rally    <= '0;
      winner   <= 1'b0;
      scorer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      armed    <= armed | ~start;
      delay_q  <= delay_d;
      score_l  <= score_l_d;
      score_r  <= score_r_d;
      rally    <= rally_d;
      winner   <= winner_d;
      scorer_q <= scorer_d;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    score_l_d = score_l;
    score_r_d = score_r;
    rally_d   = rally;
    winner_d  = winner;
    scorer_d  = scorer_q;
    case (state_q)
      IDLE, GAME_OVER: begin
        if (go_cmd) begin
          score_l_d = '0;
          score_r_d = '0;
          rally_d   = '0;
          delay_d   = '0;
          state_d   = SERVE;
        end
      end
      SERVE: begin
        if (delay_q == DELAY_LAST) begin
          delay_d = '0;
          state_d = PLAY;
        end else begin
          delay_d = delay_q + 1'b1;
        end
      end
      PLAY: begin
        if (hit && (rally != 8'hFF)) rally_d = rally + 8'd1;
        if (goal_l) begin
          scorer_d = 1'b1;
          state_d  = SCORED;
        end else if (goal_r) begin
          scorer_d = 1'b0;
          state_d  = SCORED;
        end
      end
      SCORED: begin
        rally_d = '0;
        delay_d = '0;
        state_d = SERVE;
        if (scorer_q) begin
          score_r_d = inc_r;
          if (inc_r == WIN) begin
            winner_d = 1'b1;
            state_d  = GAME_OVER;
          end
        end else begin
          score_l_d = inc_l;
          if (inc_l == WIN) begin
            winner_d = 1'b0;
            state_d  = GAME_OVER;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus queues the expected snapshot of
// every state transition; a monitor compares each transition as it happens.
module tb_game_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       start;
  logic [9:0] BallX, BallY, BallS;
  logic       hit;
  logic       ball_rst;
  logic [3:0] score_l, score_r;
  logic [7:0] rally;
  logic [2:0] state;
  logic       game_over, winner;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [2:0] st;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [7:0] ra;
    logic       go;
    logic       win;
    logic       br;
    int         dwell;   // frames spent in the previous state, -1 = any
  } exp_t;

  exp_t q[$];

  game_ctrl #(
    .SERVE_DELAY(60),
    .WIN_SCORE  (7),
    .X_MIN      (0),
    .X_MAX      (639)
  ) dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .start    (start),
    .BallX    (BallX),
    .BallY    (BallY),
    .BallS    (BallS),
    .hit      (hit),
    .ball_rst (ball_rst),
    .score_l  (score_l),
    .score_r  (score_r),
    .rally    (rally),
    .state    (state),
    .game_over(game_over),
    .winner   (winner)
  );

  always #5 frame_clk = ~frame_clk;

  // Monitor: on every state change, pop and compare the expected snapshot.
  initial begin : monitor
    logic [2:0] prev;
    int         cnt;
    int         d;
    exp_t       e;
    prev = 3'd0;
    cnt  = 0;
    forever begin
      @(negedge frame_clk);
      if (state !== prev) begin
        d    = cnt;
        cnt  = 1;
        prev = state;
        n_checks++;
        if (q.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_transition: got state=%0d sl=%0d sr=%0d rally=%0d, required no transition",
                   state, score_l, score_r, rally);
        end else begin
          e = q.pop_front();
          if (state !== e.st || score_l !== e.sl || score_r !== e.sr || rally !== e.ra ||
              game_over !== e.go || winner !== e.win || ball_rst !== e.br ||
              (e.dwell >= 0 && d != e.dwell)) begin
            n_fails++;
            $display("FAIL transition: got st=%0d sl=%0d sr=%0d ra=%0d go=%0b win=%0b br=%0b dwell=%0d; required st=%0d sl=%0d sr=%0d ra=%0d go=%0b win=%0b br=%0b dwell=%0d",
                     state, score_l, score_r, rally, game_over, winner, ball_rst, d,
                     e.st, e.sl, e.sr, e.ra, e.go, e.win, e.br, e.dwell);
          end
        end
      end else begin
        cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge frame_clk);
    #2;
  endtask

  task automatic push(input logic [2:0] st, input logic [3:0] sl, input logic [3:0] sr,
                      input logic [7:0] ra, input logic go, input logic win,
                      input logic br, input int dwell);
    exp_t e;
    e.st = st; e.sl = sl; e.sr = sr; e.ra = ra;
    e.go = go; e.win = win; e.br = br; e.dwell = dwell;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic wait_state(input logic [2:0] t, input int budget);
    int k;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (state !== t && k < budget);
    n_checks++;
    if (state !== t) begin
      n_fails++;
      $display("FAIL wait_state: got state %0d after %0d frames, required %0d", state, k, t);
    end
  endtask

  // One point from PLAY: 'hits' frames of hit, then one goal frame.
  // mode 0: back to SERVE then PLAY; 1: game over; 2: stop at SERVE.
  task automatic play_point(input logic [9:0] x, input logic [9:0] s, input int hits,
                            input logic gh, input logic [3:0] sl0, input logic [3:0] sr0,
                            input logic [7:0] ra0, input logic [3:0] sl1,
                            input logic [3:0] sr1, input int mode);
    push(3'd3, sl0, sr0, ra0, 1'b0, 1'b0, 1'b1, -1);
    if (mode == 1) begin
      push(3'd4, sl1, sr1, 8'd0, 1'b1, (sr1 == 4'd7), 1'b1, 1);
    end else begin
      push(3'd1, sl1, sr1, 8'd0, 1'b0, 1'b0, 1'b1, 1);
      if (mode == 0) push(3'd2, sl1, sr1, 8'd0, 1'b0, 1'b0, 1'b0, 60);
    end
    wait_state(3'd2, 200);
    BallX = 10'd320; BallS = 10'd4; hit = 1'b1;
    repeat (hits) tick(1);
    hit = gh; BallX = x; BallS = s;
    tick(1);
    BallX = 10'd320; BallS = 10'd4; hit = 1'b0;
  endtask

  initial begin : stim
    int k;
    Reset = 1'b1; start = 1'b0; hit = 1'b0;
    BallX = 10'd320; BallY = 10'd240; BallS = 10'd4;
    #12;
    chk("reset_state",     state,     0);
    chk("reset_ball_rst",  ball_rst,  1);
    chk("reset_score_l",   score_l,   0);
    chk("reset_score_r",   score_r,   0);
    chk("reset_rally",     rally,     0);
    chk("reset_game_over", game_over, 0);
    chk("reset_winner",    winner,    0);
    tick(1);
    Reset = 1'b0;
    tick(2);

    // Start a game: SERVE for 60 frames, then PLAY.
    push(3'd1, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, -1);
    push(3'd2, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 60);
    start = 1'b1;
    wait_state(3'd2, 100);
    // A fresh start press during PLAY must be ignored.
    start = 1'b0; tick(1);
    start = 1'b1; tick(1);

    play_point(10'd4,   10'd4,   3,   1'b1, 4'd0, 4'd0, 8'd4,   4'd0, 4'd1, 0);
    play_point(10'd2,   10'd4,   0,   1'b0, 4'd0, 4'd1, 8'd0,   4'd0, 4'd2, 0);
    // Positions one pixel inside each goal line: no goal.
    wait_state(3'd2, 200);
    BallX = 10'd5;   tick(1);
    BallX = 10'd634; tick(1);
    BallX = 10'd320;
    play_point(10'd635, 10'd4,   0,   1'b0, 4'd0, 4'd2, 8'd0,   4'd1, 4'd2, 0);
    // Both goals at once: left goal wins, right player scores.
    play_point(10'd300, 10'd400, 0,   1'b0, 4'd1, 4'd2, 8'd0,   4'd1, 4'd3, 0);
    // Rally saturation, goal in the same frame as a hit.
    play_point(10'd4,   10'd4,   300, 1'b1, 4'd1, 4'd3, 8'd255, 4'd1, 4'd4, 0);
    for (int i = 1; i <= 5; i++)
      play_point(10'd635, 10'd4, 0, 1'b0, 4'(i), 4'd4, 8'd0, 4'(i + 1), 4'd4, 0);
    play_point(10'd635, 10'd4,   0,   1'b0, 4'd6, 4'd4, 8'd0,   4'd7, 4'd4, 1);

    wait_state(3'd4, 5);
    start = 1'b0;
    tick(3);
    chk("over_score_l",   score_l,   7);
    chk("over_score_r",   score_r,   4);
    chk("over_game_over", game_over, 1);
    chk("over_winner",    winner,    0);

    // Restart from GAME_OVER.
    push(3'd1, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, -1);
    push(3'd2, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 60);
    start = 1'b1;
    play_point(10'd4, 10'd4, 0, 1'b0, 4'd0, 4'd0, 8'd0, 4'd0, 4'd1, 2);

    // Reset mid-SERVE with start held high.
    wait_state(3'd1, 5);
    tick(10);
    push(3'd0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, -1);
    #1;
    Reset = 1'b1;
    #1;
    chk("async_reset_state",   state,    0);
    chk("async_reset_score_r", score_r,  0);
    chk("async_reset_ballrst", ball_rst, 1);
    tick(3);
    Reset = 1'b0;
    tick(5);
    chk("held_start_idle", state, 0);
    start = 1'b0;
    tick(1);
    push(3'd1, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, -1);
    push(3'd2, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 60);
    start = 1'b1;
    wait_state(3'd2, 100);

    k = 0;
    while (q.size() != 0 && k < 200) begin
      tick(1);
      k++;
    end
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      n_fails++;
      $display("FAIL missing_transition: got none, required st=%0d sl=%0d sr=%0d", e.st, e.sl, e.sr);
    end
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
